// File: rtl/pll_rst_seq.sv
// PLL supervisor and staggered domain-reset sequencer on the PLL reference clock.
// Filters PLL lock, retries on lock timeout, latches a fault, re-sequences on lock loss or request.
module pll_rst_seq #(
    parameter int NUM_DOMAINS    = 4,
    parameter int PLL_RST_CYCLES = 32,
    parameter int LOCK_FILTER    = 1024,
    parameter int STAGE_GAP      = 16,
    parameter int LOCK_TIMEOUT   = 100000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   extlock,
    input  logic                   soft_req,
    output logic                   pll_reset,
    output logic [NUM_DOMAINS-1:0] domain_rstn,
    output logic                   all_ready,
    output logic                   fault,
    output logic [((MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1)-1:0] retry_cnt
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int SW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    // One shared counter serves every timed state, so it is sized for the longest interval.
    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_FILTER) ? PLL_RST_CYCLES : LOCK_FILTER;
    localparam int MAX_CD  = (STAGE_GAP > LOCK_TIMEOUT) ? STAGE_GAP : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STAGE_LAST   = SW'(NUM_DOMAINS - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_FILTER,
        ST_RELEASE,
        ST_RUN,
        ST_FAULT
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          stage_q, stage_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [NUM_DOMAINS-1:0] domain_q, domain_d;
    logic                   pll_reset_q, pll_reset_d;
    logic                   all_ready_q, all_ready_d;
    logic                   fault_q, fault_d;
    logic [1:0]             sync_q;
    logic                   lock_s;

    assign lock_s = sync_q[1];

    // extlock comes from the PLL with no relation to clk, hence the two-flop synchroniser.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], extlock};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            stage_q     <= '0;
            retry_q     <= '0;
            domain_q    <= '0;
            pll_reset_q <= 1'b1;
            all_ready_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            retry_q     <= retry_d;
            domain_q    <= domain_d;
            pll_reset_q <= pll_reset_d;
            all_ready_q <= all_ready_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        retry_d  = retry_q;
        domain_d = domain_q;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // A lock seen on the timeout cycle still counts as lock.
                if (lock_s) begin
                    state_d = ST_FILTER;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_PLL_RST;
                        retry_d = retry_q + RW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_FILTER: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == FILTER_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    stage_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RELEASE: begin
                if (!lock_s || soft_req) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d            = '0;
                    domain_d[stage_q] = 1'b1;
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                retry_d = '0;
                if (!lock_s || soft_req) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end
            end
            ST_FAULT: begin
                if (soft_req) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the next state so they switch on the same edge as the transition.
        if (state_d != ST_RELEASE && state_d != ST_RUN) begin
            domain_d = '0;
        end
        pll_reset_d = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
        all_ready_d = (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT);
    end

    assign pll_reset   = pll_reset_q;
    assign domain_rstn = domain_q;
    assign all_ready   = all_ready_q;
    assign fault       = fault_q;
    assign retry_cnt   = retry_q;

endmodule
